// File: rtl/vga_pixel_streamer_if.sv
// Wishbone classic slave bus bundle used by vga_pixel_streamer.
// Signals: cyc/stb/we/adr/dat driven by the bus master, dout/ack driven by the slave.
// Modports: master (CPU side), slave (pixel streamer side).
interface vga_pixel_streamer_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [31:0] dat;
  logic [31:0] dout;
  logic        ack;

  modport master (
    output cyc, stb, we, adr, dat,
    input  dout, ack
  );

  modport slave (
    input  cyc, stb, we, adr, dat,
    output dout, ack
  );
endinterface

// File: rtl/vga_pixel_streamer.sv
// Purpose: CPU-filled pixel FIFO feeding registered RGB and delayed sync outputs to the VGA output.
// Latency: 1 cycle from display_enable/row/column/sync inputs to rgb/de_o/h_sync_o/v_sync_o.
// Backpressure: a DATA write while the FIFO is full gets no ack until a pop frees a slot.
//
// Ports:
//   clk, async_reset             - shared pixel/bus clock, asynchronous active-low reset
//   wb (slave modport)           - Wishbone classic register port, 4 words decoded on adr[3:2]:
//                                  0 DATA (push), 1 STATUS {full,empty,level}, 2 CTRL
//                                  {bg[27:16], flush[1], enable[0]}, 3 UNDERFLOW count
//   display_enable, row, column  - active video qualifier and pixel coordinates
//   h_sync, v_sync               - sync levels, re-timed to line up with rgb
//   rgb, de_o, h_sync_o, v_sync_o- registered pixel outputs
// Build option: define VGA_UNDERFLOW_COUNT_EN to implement the 16-bit saturating
// underflow counter; without it UNDERFLOW reads 0 and writes to it are ignored.
module vga_pixel_streamer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic                 clk,
  input  logic                 async_reset,
  vga_pixel_streamer_if.slave  wb,
  input  logic                 display_enable,
  input  logic [11:0]          row,
  input  logic [11:0]          column,
  input  logic                 h_sync,
  input  logic                 v_sync,
  output logic [11:0]          rgb,
  output logic                 de_o,
  output logic                 h_sync_o,
  output logic                 v_sync_o
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_STREAM = 2'd2;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_UNDER  = 2'd3;

  localparam logic [AW:0] LEVEL_FULL = (AW+1)'(DEPTH);

  logic [1:0]    state_q, state_d;
  logic          ctrl_en_q, ctrl_en_d;
  logic [11:0]   bg_q, bg_d;
  logic          ack_q, ack_d;
  logic [31:0]   dout_q, dout_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic [11:0]   rgb_q, rgb_d;
  logic          de_q, hs_q, vs_q;
  logic [11:0]   mem_q [DEPTH];

  logic          fifo_full, fifo_empty;
  logic [1:0]    reg_sel;
  logic          bus_req, data_stall, bus_acc, bus_wr;
  logic          push, flush, frame_start, pop, pop_hit;
  logic [31:0]   rdata;

  assign fifo_full  = (level_q == LEVEL_FULL);
  assign fifo_empty = (level_q == '0);

  // A new access is only taken while ack is low, so ack is a single-cycle pulse
  // followed by at least one low cycle even if the master keeps stb asserted.
  assign reg_sel    = wb.adr[3:2];
  assign bus_req    = wb.cyc && wb.stb && !ack_q;
  assign data_stall = bus_req && wb.we && (reg_sel == REG_DATA) && fifo_full;
  assign bus_acc    = bus_req && !data_stall;
  assign bus_wr     = bus_acc && wb.we;

  assign push  = bus_wr && (reg_sel == REG_DATA);
  assign flush = bus_wr && (reg_sel == REG_CTRL) && wb.dat[1];

  // The first pop of a frame happens on the very cycle the frame origin is seen.
  assign frame_start = display_enable && (row == 12'd0) && (column == 12'd0);
  assign pop = ctrl_en_q && !flush && display_enable &&
               (((state_q == ST_WAIT) && frame_start) || (state_q == ST_STREAM));
  // Popping an empty FIFO is an underflow: no pointer movement, background shown.
  assign pop_hit = pop && !fifo_empty;

  logic unused_bits;
  assign unused_bits = ^{wb.adr[31:4], wb.adr[1:0], wb.dat[31:28], wb.dat[15:12]};

`ifdef VGA_UNDERFLOW_COUNT_EN
  logic [15:0] underflow_q, underflow_d;

  always_comb begin
    underflow_d = underflow_q;
    if (pop && fifo_empty && (underflow_q != 16'hFFFF)) begin
      underflow_d = underflow_q + 16'd1;
    end
    if (bus_wr && (reg_sel == REG_UNDER)) begin
      underflow_d = '0;
    end
  end

  always_ff @(posedge clk or negedge async_reset) begin
    if (!async_reset) begin
      underflow_q <= '0;
    end else begin
      underflow_q <= underflow_d;
    end
  end
`endif

  always_comb begin
    rdata = '0;
    case (reg_sel)
      REG_STATUS: rdata = {21'd0, fifo_full, fifo_empty, 9'(level_q)};
      REG_CTRL:   rdata = {4'd0, bg_q, 14'd0, 1'b0, ctrl_en_q};
`ifdef VGA_UNDERFLOW_COUNT_EN
      REG_UNDER:  rdata = {16'd0, underflow_q};
`endif
      default:    rdata = '0;
    endcase
  end

  always_comb begin
    ack_d  = bus_acc;
    dout_d = (bus_acc && !wb.we) ? rdata : '0;

    ctrl_en_d = ctrl_en_q;
    bg_d      = bg_q;
    if (bus_wr && (reg_sel == REG_CTRL)) begin
      ctrl_en_d = wb.dat[0];
      bg_d      = wb.dat[27:16];
    end

    state_d = state_q;
    if (flush) begin
      // Flush restarts the frame hunt with the enable value written alongside it.
      state_d = ctrl_en_d ? ST_WAIT : ST_IDLE;
    end else if (!ctrl_en_q) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_WAIT;
        ST_WAIT: if (pop) state_d = ST_STREAM;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push)    wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_hit) rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop_hit) begin
        level_d = level_q + (AW+1)'(1);
      end else if (!push && pop_hit) begin
        level_d = level_q - (AW+1)'(1);
      end
    end
  end

  always_comb begin
    rgb_d = 12'h000;
    if (display_enable) begin
      rgb_d = pop_hit ? mem_q[rd_ptr_q] : bg_q;
    end
  end

  // Pixel storage carries no reset; validity is tracked by the pointers and level.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wb.dat[11:0];
    end
  end

  always_ff @(posedge clk or negedge async_reset) begin
    if (!async_reset) begin
      state_q   <= ST_IDLE;
      ctrl_en_q <= 1'b0;
      bg_q      <= '0;
      ack_q     <= 1'b0;
      dout_q    <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      rgb_q     <= '0;
      de_q      <= 1'b0;
      hs_q      <= 1'b0;
      vs_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctrl_en_q <= ctrl_en_d;
      bg_q      <= bg_d;
      ack_q     <= ack_d;
      dout_q    <= dout_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      rgb_q     <= rgb_d;
      de_q      <= display_enable;
      hs_q      <= h_sync;
      vs_q      <= v_sync;
    end
  end

  assign wb.ack   = ack_q;
  assign wb.dout  = dout_q;
  assign rgb      = rgb_q;
  assign de_o     = de_q;
  assign h_sync_o = hs_q;
  assign v_sync_o = vs_q;

endmodule

// File: tb/tb_vga_pixel_streamer.sv
// Bench for vga_pixel_streamer: queue-based reference model checked every cycle,
// plus directed sequences with hand-computed expected pixels and register reads.
// Inputs change 1-2 time units after a rising edge; outputs are compared on the falling edge.
module tb_vga_pixel_streamer;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
`ifdef VGA_UNDERFLOW_COUNT_EN
  localparam bit UNDER_ON = 1'b1;
`else
  localparam bit UNDER_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        async_reset = 1'b0;
  logic        display_enable = 1'b0;
  logic [11:0] row = '0;
  logic [11:0] column = '0;
  logic        h_sync = 1'b0;
  logic        v_sync = 1'b0;
  logic [11:0] rgb;
  logic        de_o, h_sync_o, v_sync_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vga_pixel_streamer_if wb();

  vga_pixel_streamer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk            (clk),
    .async_reset    (async_reset),
    .wb             (wb),
    .display_enable (display_enable),
    .row            (row),
    .column         (column),
    .h_sync         (h_sync),
    .v_sync         (v_sync),
    .rgb            (rgb),
    .de_o           (de_o),
    .h_sync_o       (h_sync_o),
    .v_sync_o       (v_sync_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          q[$];
  bit          m_en = 1'b0;
  logic [11:0] m_bg = '0;
  int          m_under = 0;
  int          m_mode = 0;   // 0 off, 1 hunting for frame origin, 2 streaming
  logic        m_ack = 1'b0;
  logic [31:0] m_dout = '0;
  logic [11:0] m_rgb = '0;
  logic        m_de = 1'b0, m_hs = 1'b0, m_vs = 1'b0;

  task automatic model_reset();
    q.delete();
    m_en = 1'b0; m_bg = '0; m_under = 0; m_mode = 0;
    m_ack = 1'b0; m_dout = '0; m_rgb = '0; m_de = 1'b0; m_hs = 1'b0; m_vs = 1'b0;
  endtask

  task automatic model_step();
    bit full, empty, req, acc, wr, flush, pop;
    logic [1:0]  sel;
    logic [31:0] rd;
    full  = (q.size() == DEPTH);
    empty = (q.size() == 0);
    sel   = wb.adr[3:2];
    req   = wb.cyc && wb.stb && !m_ack;
    acc   = req && !(wb.we && sel == 2'd0 && full);
    wr    = acc && wb.we;
    flush = wr && sel == 2'd2 && wb.dat[1];
    pop   = m_en && !flush && display_enable &&
            ((m_mode == 1 && row == 12'd0 && column == 12'd0) || m_mode == 2);
    case (sel)
      2'd1:    rd = (full ? 32'h400 : 32'h0) | (empty ? 32'h200 : 32'h0) | 32'(q.size());
      2'd2:    rd = {4'h0, m_bg, 15'h0, m_en};
      2'd3:    rd = UNDER_ON ? 32'(m_under) : 32'h0;
      default: rd = 32'h0;
    endcase
    m_dout = (acc && !wb.we) ? rd : 32'h0;
    m_ack  = acc;
    if (!display_enable)     m_rgb = 12'h000;
    else if (pop && !empty)  m_rgb = 12'(q[0]);
    else                     m_rgb = m_bg;
    if (pop) begin
      if (empty) begin
        if (m_under < 65535) m_under++;
      end else begin
        void'(q.pop_front());
      end
    end
    if (wr && sel == 2'd0) q.push_back(int'(wb.dat[11:0]));
    if (wr && sel == 2'd3) m_under = 0;
    if (flush) begin
      q.delete();
      m_mode = wb.dat[0] ? 1 : 0;
    end else if (!m_en) m_mode = 0;
    else if (m_mode == 0) m_mode = 1;
    else if (m_mode == 1 && pop) m_mode = 2;
    if (wr && sel == 2'd2) begin
      m_en = wb.dat[0];
      m_bg = wb.dat[27:16];
    end
    m_de = display_enable;
    m_hs = h_sync;
    m_vs = v_sync;
  endtask

  initial forever begin
    @(posedge clk or negedge async_reset);
    if (!async_reset) model_reset();
    else model_step();
  end

  // Every-cycle comparison of all outputs against the model.
  initial forever begin
    @(negedge clk);
    if (async_reset) begin
      check("ack", wb.ack, m_ack);
      check("dout", wb.dout, m_dout);
      check("rgb", rgb, m_rgb);
      check("de_o", de_o, m_de);
      check("h_sync_o", h_sync_o, m_hs);
      check("v_sync_o", v_sync_o, m_vs);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wb_xfer(input bit w, input logic [1:0] r, input logic [31:0] d,
                         output logic [31:0] rd);
    int n;
    n = 0;
    @(posedge clk); #2;
    wb.cyc = 1'b1; wb.stb = 1'b1; wb.we = w; wb.adr = {28'h0, r, 2'b00}; wb.dat = d;
    do begin
      @(negedge clk);
      n++;
    end while (!wb.ack && n < 40);
    rd = wb.dout;
    check("wb_ack_seen", wb.ack, 1);
    @(posedge clk); #2;
    wb.cyc = 1'b0; wb.stb = 1'b0; wb.we = 1'b0;
  endtask

  task automatic wb_write(input logic [1:0] r, input logic [31:0] d);
    logic [31:0] rd;
    wb_xfer(1'b1, r, d, rd);
  endtask

  task automatic wb_read_chk(input string name, input logic [1:0] r, input logic [31:0] exp);
    logic [31:0] rd;
    wb_xfer(1'b0, r, 32'h0, rd);
    check(name, rd, exp);
  endtask

  // Drive one pixel cycle now; return 1 unit after the edge that sampled it.
  task automatic px(input bit de, input int r, input int c);
    display_enable = de;
    row    = 12'(r);
    column = 12'(c);
    h_sync = c[1];
    v_sync = (r == 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    wb.cyc = 1'b0; wb.stb = 1'b0; wb.we = 1'b0; wb.adr = '0; wb.dat = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_rgb", rgb, 12'h000);
    check("reset_ack", wb.ack, 0);
    check("reset_dout", wb.dout, 0);
    check("reset_de_o", de_o, 0);
    #1 async_reset = 1'b1;
    wb_read_chk("status_after_reset", 2'd1, 32'h200);
    wb_read_chk("ctrl_after_reset", 2'd2, 32'h0);

    // Fill to full, then a 17th write stalls until one pop frees a slot
    for (int i = 1; i <= 16; i++) wb_write(2'd0, 32'(i));
    wb_read_chk("status_full", 2'd1, 32'h410);
    wb_write(2'd2, 32'h0000_0001);
    fork
      wb_write(2'd0, 32'h0FF);
      begin
        repeat (4) begin
          @(negedge clk);
          check("stall_no_ack", wb.ack, 0);
        end
        px(1, 0, 0);
        check("stall_pop_rgb", rgb, 12'h001);
        px(0, 1, 0);
      end
    join
    wb_read_chk("status_full_again", 2'd1, 32'h410);

    // Mid-frame enable: nothing pops until the frame origin
    wb_write(2'd2, 32'h0);
    wb_write(2'd2, 32'h2);
    wb_read_chk("status_flushed", 2'd1, 32'h200);
    for (int i = 1; i <= 4; i++) wb_write(2'd0, 32'(i));
    wb_write(2'd2, 32'h00A5_0001);
    px(1, 3, 5);
    check("wait_bg_rgb", rgb, 12'h0A5);
    px(1, 3, 6);
    px(0, 3, 7);
    check("blank_rgb", rgb, 12'h000);
    check("blank_de_o", de_o, 0);
    for (int i = 0; i < 4; i++) begin
      px(1, 0, i);
      check("frame_pixel", rgb, 32'(i + 1));
      check("frame_de_o", de_o, 1);
    end
    px(0, 0, 4);
    wb_read_chk("status_drained", 2'd1, 32'h200);

    // Underflow with background 0xF0F
    wb_write(2'd3, 32'h0);
    wb_write(2'd2, 32'h0F0F_0001);
    for (int i = 0; i < 3; i++) begin
      px(1, 1, i);
      check("underflow_bg", rgb, 12'hF0F);
    end
    px(0, 1, 3);
    wb_read_chk("underflow_count", 2'd3, UNDER_ON ? 32'd3 : 32'd0);
    wb_write(2'd3, 32'h1);
    wb_read_chk("underflow_cleared", 2'd3, 32'd0);

    // Flush at level 5 while streaming, then fresh data from next frame origin
    for (int i = 1; i <= 7; i++) wb_write(2'd0, 32'h100 + 32'(i));
    px(1, 1, 0);
    check("stream_pop1", rgb, 12'h101);
    px(1, 1, 1);
    check("stream_pop2", rgb, 12'h102);
    px(0, 1, 2);
    wb_read_chk("status_level5", 2'd1, 32'h005);
    wb_write(2'd2, 32'h0F0F_0003);
    wb_read_chk("status_after_flush", 2'd1, 32'h200);
    wb_write(2'd0, 32'h201);
    wb_write(2'd0, 32'h202);
    px(1, 2, 0);
    check("flush_wait_bg", rgb, 12'hF0F);
    px(1, 0, 0);
    check("fresh_pop1", rgb, 12'h201);
    px(1, 0, 1);
    check("fresh_pop2", rgb, 12'h202);
    px(0, 0, 2);

    // Reset asserted mid-line with a bus access in flight
    px(1, 1, 3);
    check("pre_reset_rgb", rgb, 12'hF0F);
    check("pre_reset_hs", h_sync_o, 1);
    wb.cyc = 1'b1; wb.stb = 1'b1; wb.we = 1'b0; wb.adr = 32'h8;
    #5 async_reset = 1'b0;
    #1;
    check("rst_rgb", rgb, 12'h000);
    check("rst_de_o", de_o, 0);
    check("rst_h_sync_o", h_sync_o, 0);
    check("rst_ack", wb.ack, 0);
    repeat (3) begin
      @(negedge clk);
      check("rst_ack_held", wb.ack, 0);
    end
    wb.cyc = 1'b0; wb.stb = 1'b0;
    display_enable = 1'b0;
    @(posedge clk); #2;
    async_reset = 1'b1;
    wb_read_chk("status_post_reset", 2'd1, 32'h200);
    wb_read_chk("ctrl_post_reset", 2'd2, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
